tdm_demux2: RTL and testbench

Two-channel time-division demultiplexer: the receive end of the 2:1 mux path. It takes a single sample stream that alternates between channel A (slot 0) and channel B (slot 1), marked by a frame-sync strobe on slot 0. It acquires and tracks frame alignment and steers each sample into a registered per-channel output with a one-cycle valid pulse. It sits downstream of `mux2t1`-style serializers, where `sel` toggles per sample.

---
 rtl/tdm_demux2.sv | 132 +++++++++++++
 tb/tb_tdm_demux2.sv | 184 ++++++++++++++++++
 2 files changed

// File: rtl/tdm_demux2.sv
// tdm_demux2: two-channel TDM receiver with frame-sync acquisition, flywheel tracking
// and per-channel registered outputs. Define TDM_DEMUX_ERRCNT_EN to add the
// saturating frame-error counter on err_cnt.
module tdm_demux2 #(
    parameter int W           = 1,
    parameter int LOCK_FRAMES = 2,
    parameter int MISS_MAX    = 2
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    input  logic [W-1:0] in_data,
    input  logic         fsync,
    output logic [W-1:0] a,
    output logic [W-1:0] b,
    output logic         a_vld,
    output logic         b_vld,
    output logic         sel,
    output logic         locked
`ifdef TDM_DEMUX_ERRCNT_EN
    ,
    output logic [7:0]   err_cnt
`endif
);
    localparam int GW = $clog2(LOCK_FRAMES + 1);
    localparam int MW = $clog2(MISS_MAX + 1);
    localparam logic [GW-1:0] LF_M1 = GW'(LOCK_FRAMES - 1);
    localparam logic [MW-1:0] MM_M1 = MW'(MISS_MAX - 1);

    typedef enum logic [1:0] {S_HUNT, S_SYNC, S_LOCKED} state_t;

    state_t        r_state;
    logic [GW-1:0] r_good;
    logic [MW-1:0] r_miss;

`ifdef TDM_DEMUX_ERRCNT_EN
    function automatic logic [7:0] sat_add(input logic [7:0] c, input logic [1:0] n);
        logic [8:0] s;
        s = {1'b0, c} + {7'b0, n};
        return s[8] ? 8'hff : s[7:0];
    endfunction
`endif

    // Alignment FSM: only accepted samples advance slot/state; outputs hold across gaps.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_HUNT;
            r_good  <= '0;
            r_miss  <= '0;
            sel     <= 1'b0;
            locked  <= 1'b0;
            a       <= '0;
            b       <= '0;
            a_vld   <= 1'b0;
            b_vld   <= 1'b0;
`ifdef TDM_DEMUX_ERRCNT_EN
            err_cnt <= '0;
`endif
        end else begin
            a_vld <= 1'b0;
            b_vld <= 1'b0;
            if (in_valid) begin
                case (r_state)
                    S_HUNT: begin
                        if (fsync) begin
                            sel    <= 1'b1;
                            r_good <= GW'(1);
                            if (LOCK_FRAMES == 1) begin
                                r_state <= S_LOCKED;
                                locked  <= 1'b1;
                                r_miss  <= '0;
                                a       <= in_data;
                                a_vld   <= 1'b1;
                            end else begin
                                r_state <= S_SYNC;
                            end
                        end
                    end
                    S_SYNC: begin
                        if (!sel && fsync) begin
                            sel    <= 1'b1;
                            r_good <= r_good + GW'(1);
                            if (r_good == LF_M1) begin
                                r_state <= S_LOCKED;
                                locked  <= 1'b1;
                                r_miss  <= '0;
                                a       <= in_data;
                                a_vld   <= 1'b1;
                            end
                        end else if (!sel) begin
                            r_state <= S_HUNT;
                            sel     <= 1'b0;
                        end else begin
                            sel    <= fsync;
                            r_good <= fsync ? GW'(1) : r_good;
                        end
                    end
                    default: begin
                        if (!sel && fsync) begin
                            r_miss <= '0;
                            sel    <= 1'b1;
                            a      <= in_data;
                            a_vld  <= 1'b1;
                        end else if (!sel || fsync) begin
                            if (r_miss == MM_M1) begin
                                r_state <= S_HUNT;
                                locked  <= 1'b0;
                                sel     <= 1'b0;
                                r_miss  <= '0;
`ifdef TDM_DEMUX_ERRCNT_EN
                                err_cnt <= sat_add(err_cnt, 2'd2);
`endif
                            end else begin
                                r_miss <= r_miss + MW'(1);
                                sel    <= 1'b1;
                                a      <= in_data;
                                a_vld  <= 1'b1;
`ifdef TDM_DEMUX_ERRCNT_EN
                                err_cnt <= sat_add(err_cnt, 2'd1);
`endif
                            end
                        end else begin
                            sel   <= 1'b0;
                            b     <= in_data;
                            b_vld <= 1'b1;
                        end
                    end
                endcase
            end
        end
    end
endmodule

// File: tb/tb_tdm_demux2.sv
// tb_tdm_demux2: scoreboard bench for tdm_demux2 with a behavioural alignment model
module tb_tdm_demux2;
    localparam int W  = 1;
    localparam int LF = 2;
    localparam int MM = 2;

    logic clk = 1'b0;
    logic rst = 1'b0;
    logic in_valid = 1'b0;
    logic fsync = 1'b0;
    logic [W-1:0] in_data = '0;
    logic [W-1:0] a, b;
    logic a_vld, b_vld, sel, locked;
`ifdef TDM_DEMUX_ERRCNT_EN
    logic [7:0] err_cnt;
`endif

    int errors = 0;
    int checks = 0;
    int del_q[$];
    int st_q[$];
    int m_mode, m_slot, m_good, m_miss, m_err;
    int g_slot;
    logic acc_d;

    always #5 clk = ~clk;

    tdm_demux2 #(.W(W), .LOCK_FRAMES(LF), .MISS_MAX(MM)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_data(in_data), .fsync(fsync),
        .a(a), .b(b), .a_vld(a_vld), .b_vld(b_vld), .sel(sel), .locked(locked)
`ifdef TDM_DEMUX_ERRCNT_EN
        , .err_cnt(err_cnt)
`endif
    );

    task automatic chk(input string nm, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic int sat(input int v);
        return v > 255 ? 255 : v;
    endfunction

    task automatic model_reset();
        m_mode = 0; m_slot = 0; m_good = 0; m_miss = 0; m_err = 0;
        del_q.delete();
        st_q.delete();
    endtask

    // mode 0 = hunting, 1 = confirming, 2 = locked; deliveries encoded as channel*2+data
    task automatic model(input bit fs, input int d);
        bit slot0;
        slot0 = (m_slot == 0);
        if (m_mode == 0) begin
            if (fs) begin
                m_good = 1; m_slot = 1;
                if (m_good >= LF) begin m_mode = 2; m_miss = 0; del_q.push_back(d); end
                else m_mode = 1;
            end
        end else if (m_mode == 1) begin
            if (slot0 && !fs) begin m_mode = 0; m_slot = 0; end
            else if (slot0) begin
                m_good++; m_slot = 1;
                if (m_good >= LF) begin m_mode = 2; m_miss = 0; del_q.push_back(d); end
            end else if (fs) begin m_good = 1; m_slot = 1; end
            else m_slot = 0;
        end else begin
            if (slot0 == fs) begin
                if (slot0) begin m_miss = 0; m_slot = 1; del_q.push_back(d); end
                else begin m_slot = 0; del_q.push_back(2 + d); end
            end else begin
                m_miss++;
                m_err = sat(m_err + 1);
                if (m_miss >= MM) begin
                    m_mode = 0; m_slot = 0; m_miss = 0; m_err = sat(m_err + 1);
                end else begin
                    m_slot = 1; del_q.push_back(d);
                end
            end
        end
        st_q.push_back(m_slot + 2 * int'(m_mode == 2) + 4 * m_err);
    endtask

    task automatic send(input bit v, input bit fs, input int d);
        @(posedge clk); #1;
        in_valid = v; fsync = fs; in_data = W'(d);
        if (v) model(fs, d);
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, "_a"}, int'(a), 0);
        chk({tag, "_b"}, int'(b), 0);
        chk({tag, "_a_vld"}, int'(a_vld), 0);
        chk({tag, "_b_vld"}, int'(b_vld), 0);
        chk({tag, "_sel"}, int'(sel), 0);
        chk({tag, "_locked"}, int'(locked), 0);
`ifdef TDM_DEMUX_ERRCNT_EN
        chk({tag, "_err_cnt"}, int'(err_cnt), 0);
`endif
    endtask

    always @(posedge clk or posedge rst) acc_d <= rst ? 1'b0 : in_valid;

    // Monitor: pop a delivery on every valid pulse, and a status snapshot after each accepted sample
    always @(negedge clk) begin
        int e;
        if (!rst) begin
            if (a_vld && b_vld) chk("both_vld", 1, 0);
            if (a_vld || b_vld) begin
                if (del_q.size() == 0) chk("unexpected_vld", 1, 0);
                else begin
                    e = del_q.pop_front();
                    chk("dlv_chan", int'(b_vld), e / 2);
                    chk("dlv_data", int'(b_vld ? b : a), e % 2);
                end
            end
            if (acc_d) begin
                if (st_q.size() == 0) chk("status_underflow", 1, 0);
                else begin
                    e = st_q.pop_front();
                    chk("sel", int'(sel), e % 2);
                    chk("locked", int'(locked), (e / 2) % 2);
`ifdef TDM_DEMUX_ERRCNT_EN
                    chk("err_cnt", int'(err_cnt), e / 4);
`endif
                end
            end
        end
    end

    initial begin
        model_reset();
        #2 rst = 1'b1;
        repeat (2) @(posedge clk);
        #1 chk_zero("reset");
        rst = 1'b0;
        // lock acquisition
        send(1, 1, 1); send(1, 0, 0); send(1, 1, 0); send(1, 0, 1);
        // gaps between slot 0 and slot 1
        send(1, 1, 1); send(0, 0, 0); send(0, 0, 0); send(0, 0, 0);
        chk("gap_sel", int'(sel), 1);
        chk("gap_locked", int'(locked), 1);
        send(1, 0, 1);
        // single miss then good frame
        send(1, 0, 1); send(1, 0, 0); send(1, 1, 0); send(1, 0, 1);
        // loss of lock
        send(1, 0, 1); send(1, 0, 0); send(1, 0, 1); send(0, 0, 0);
        chk("lost_locked", int'(locked), 0);
        chk("lost_sel", int'(sel), 0);
        // relock
        send(1, 1, 0); send(1, 0, 1); send(1, 1, 1); send(1, 0, 0);
        // misplaced fsync on slot 1
        send(1, 1, 0); send(1, 1, 1); send(1, 0, 0);
        send(1, 1, 1); send(1, 0, 1);
        // async reset between slot 0 and slot 1
        send(1, 1, 1);
        @(posedge clk); #1;
        in_valid = 1'b0;
        #1 rst = 1'b1;
        model_reset();
        #1 chk_zero("async_rst");
        @(posedge clk); #1 rst = 1'b0;
        send(1, 0, 1); send(0, 0, 0);
        chk("post_rst_locked", int'(locked), 0);
        // randomized traffic with occasional frame errors and gaps
        g_slot = 0;
        for (int i = 0; i < 3000; i++) begin
            bit v, fs;
            v = ($urandom_range(0, 3) != 0);
            fs = (g_slot == 0) ^ ($urandom_range(0, 11) == 0);
            send(v, fs, int'($urandom_range(0, 1)));
            if (v) g_slot ^= 1;
        end
        repeat (3) send(0, 0, 0);
        chk("del_q_empty", del_q.size(), 0);
        chk("st_q_empty", st_q.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
